// File: rtl/spi_wrapper_master_if.sv
// Command/response handshake between an upstream requester and the SPI wrapper master.
interface spi_wrapper_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_wrapper_master.sv
// SPI master that turns RAM commands into 11-bit SS_n frames and returns read bytes.
// Optional command-order checker (seq_err output) enabled by defining SPI_MASTER_SEQ_CHK_EN.
module spi_wrapper_master #(
    parameter int READ_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_wrapper_master_if.slave        cmd,
    output logic                       busy,
    output logic                       SS_n,
    output logic                       MOSI,
    input  logic                       MISO
`ifdef SPI_MASTER_SEQ_CHK_EN
    ,
    output logic                       seq_err
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_END
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] tx_q, tx_d;
    logic        rd_q, rd_d;
    logic [7:0]  rx_q, rx_d;
    logic        mosi_q, mosi_d;
    logic        ss_n_q, ss_n_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        accept;

`ifdef SPI_MASTER_SEQ_CHK_EN
    logic        have_raddr_q, have_raddr_d;
    logic        have_waddr_q, have_waddr_d;
    logic        seq_err_q, seq_err_d;
`endif

    assign accept = (state_q == ST_IDLE) && cmd.cmd_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rd_d        = rd_q;
        rx_d        = rx_q;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEL;
                    tx_d    = {cmd.cmd_op[1], cmd.cmd_op, cmd.cmd_data};
                    rd_d    = (cmd.cmd_op == 2'b11);
                end
            end
            // tx_q always holds the next bit to present in bit 10
            ST_SEL: begin
                state_d = ST_SHIFT;
                cnt_d   = 4'd10;
                mosi_d  = tx_q[10];
                tx_d    = {tx_q[9:0], 1'b0};
            end
            ST_SHIFT: begin
                if (cnt_q == 4'd0) begin
                    if (rd_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(READ_LAT - 1);
                    end else begin
                        state_d = ST_END;
                    end
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    mosi_d = tx_q[10];
                    tx_d   = {tx_q[9:0], 1'b0};
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RECV;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECV: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 4'd0) begin
                    state_d     = ST_END;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {rx_q[6:0], MISO};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin-level outputs are registered from the next state so they line up with it
        ss_n_d  = (state_d == ST_IDLE) || (state_d == ST_END);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

`ifdef SPI_MASTER_SEQ_CHK_EN
    always_comb begin
        have_raddr_d = have_raddr_q;
        have_waddr_d = have_waddr_q;
        seq_err_d    = 1'b0;
        if (accept) begin
            case (cmd.cmd_op)
                2'b00: have_waddr_d = 1'b1;
                2'b01: seq_err_d    = !have_waddr_q;
                2'b10: have_raddr_d = 1'b1;
                2'b11: begin
                    seq_err_d    = !have_raddr_q;
                    have_raddr_d = 1'b0;
                end
                default: seq_err_d = 1'b0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            tx_q        <= 11'd0;
            rd_q        <= 1'b0;
            rx_q        <= 8'd0;
            mosi_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
`ifdef SPI_MASTER_SEQ_CHK_EN
            have_raddr_q <= 1'b0;
            have_waddr_q <= 1'b0;
            seq_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rd_q        <= rd_d;
            rx_q        <= rx_d;
            mosi_q      <= mosi_d;
            ss_n_q      <= ss_n_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef SPI_MASTER_SEQ_CHK_EN
            have_raddr_q <= have_raddr_d;
            have_waddr_q <= have_waddr_d;
            seq_err_q    <= seq_err_d;
`endif
        end
    end

    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign busy          = busy_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;
`ifdef SPI_MASTER_SEQ_CHK_EN
    assign seq_err       = seq_err_q;
`endif

endmodule

// File: tb/tb_spi_wrapper_master.sv
// Directed bench for spi_wrapper_master: table of single frames plus hand-written multi-frame sequences.
module tb_spi_wrapper_master;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic SS_n;
    logic MOSI;
    logic MISO;
`ifdef SPI_MASTER_SEQ_CHK_EN
    logic seq_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int seq_hits     = 0;

    always #5 clk = ~clk;

    spi_wrapper_master_if bus ();

    spi_wrapper_master #(.READ_LAT(RL)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (bus),
        .busy (busy),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
`ifdef SPI_MASTER_SEQ_CHK_EN
        ,
        .seq_err (seq_err)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        logic [7:0]  miso_byte;
        logic        miso_idle;
        int          exp_end;
        logic [10:0] exp_mosi;
        int          exp_rsp_cnt;
        logic [7:0]  exp_rsp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for the negedge where cmd_ready is high; the following posedge is the accept edge
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] data,
                                  input logic [7:0] miso_byte, input logic miso_idle,
                                  output int end_cyc, output int low_cnt,
                                  output logic [10:0] mosi_bits, output int rsp_cnt,
                                  output logic [7:0] rsp_byte);
        bit ok;
        end_cyc   = -1;
        low_cnt   = 0;
        mosi_bits = 11'd0;
        rsp_cnt   = 0;
        rsp_byte  = 8'h00;
        MISO      = miso_idle;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        wait_accept(ok);
        check_output("accept", 32'(ok), 32'd1);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_data  = ~data;
        for (int c = 0; c < 60; c++) begin
`ifdef SPI_MASTER_SEQ_CHK_EN
            if (seq_err === 1'b1) seq_hits++;
`endif
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                rsp_byte = bus.rsp_data;
            end
            if (SS_n === 1'b1) begin
                end_cyc = c;
                break;
            end
            low_cnt++;
            if (c >= 1 && c <= 11) mosi_bits[11 - c] = MOSI;
            if (c >= 12 + RL && c < 20 + RL) MISO = miso_byte[7 - (c - 12 - RL)];
            else                             MISO = miso_idle;
            @(posedge clk);
            #1;
        end
        MISO = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          end_cyc, low_cnt, rsp_cnt, gap;
        logic [10:0] mosi_bits, f1, f2;
        logic [7:0]  rsp_byte;
        logic        ss  [40];
        logic        mo  [40];
        int          rv_cnt;
        bit          ok;

        vecs[0] = '{2'b00, 8'h3C, 8'h00, 1'b0, 12, 11'b000_0011_1100, 0, 8'h00};
        vecs[1] = '{2'b01, 8'hA5, 8'h00, 1'b0, 12, 11'b001_1010_0101, 0, 8'h00};
        vecs[2] = '{2'b10, 8'h3C, 8'h00, 1'b1, 12, 11'b110_0011_1100, 0, 8'h00};
        vecs[3] = '{2'b11, 8'h00, 8'hA5, 1'b1, 22, 11'b111_0000_0000, 1, 8'hA5};
        vecs[4] = '{2'b10, 8'h81, 8'h00, 1'b0, 12, 11'b110_1000_0001, 0, 8'h00};
        vecs[5] = '{2'b11, 8'hFF, 8'h5A, 1'b1, 22, 11'b111_1111_1111, 1, 8'h5A};

        rst           = 1'b1;
        MISO          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("rst_ss_n",      32'(SS_n),          32'd1);
        check_output("rst_mosi",      32'(MOSI),          32'd0);
        check_output("rst_ready",     32'(bus.cmd_ready), 32'd1);
        check_output("rst_busy",      32'(busy),          32'd0);
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst_rsp_data",  32'(bus.rsp_data),  32'd0);

        // Command-order checker: read data and write data before any address
        seq_hits = 0;
        apply_stimulus(2'b11, 8'h00, 8'hC3, 1'b0, end_cyc, low_cnt, mosi_bits, rsp_cnt, rsp_byte);
        check_output("seq_rd_end", 32'(end_cyc), 32'd22);
        check_output("seq_rd_rsp", 32'(rsp_byte), 32'hC3);
`ifdef SPI_MASTER_SEQ_CHK_EN
        check_output("seq_err_rd_no_addr", 32'(seq_hits), 32'd1);
`endif
        seq_hits = 0;
        apply_stimulus(2'b01, 8'h11, 8'h00, 1'b0, end_cyc, low_cnt, mosi_bits, rsp_cnt, rsp_byte);
        check_output("seq_wr_end", 32'(end_cyc), 32'd12);
`ifdef SPI_MASTER_SEQ_CHK_EN
        check_output("seq_err_wr_no_addr", 32'(seq_hits), 32'd1);
`endif
        seq_hits = 0;
        apply_stimulus(2'b10, 8'h3C, 8'h00, 1'b0, end_cyc, low_cnt, mosi_bits, rsp_cnt, rsp_byte);
        apply_stimulus(2'b11, 8'h00, 8'h0F, 1'b0, end_cyc, low_cnt, mosi_bits, rsp_cnt, rsp_byte);
        check_output("seq_ok_rsp", 32'(rsp_byte), 32'h0F);
`ifdef SPI_MASTER_SEQ_CHK_EN
        check_output("seq_err_ordered", 32'(seq_hits), 32'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].data, vecs[i].miso_byte, vecs[i].miso_idle,
                           end_cyc, low_cnt, mosi_bits, rsp_cnt, rsp_byte);
            check_output($sformatf("vec%0d_end", i),     32'(end_cyc),   32'(vecs[i].exp_end));
            check_output($sformatf("vec%0d_low", i),     32'(low_cnt),   32'(vecs[i].exp_end));
            check_output($sformatf("vec%0d_mosi", i),    32'(mosi_bits), 32'(vecs[i].exp_mosi));
            check_output($sformatf("vec%0d_rsp_cnt", i), 32'(rsp_cnt),   32'(vecs[i].exp_rsp_cnt));
            if (vecs[i].exp_rsp_cnt != 0)
                check_output($sformatf("vec%0d_rsp_data", i), 32'(rsp_byte), 32'(vecs[i].exp_rsp_data));
        end

        // Back-to-back with cmd_valid held and inputs changing mid-frame
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 8'hA5;
        wait_accept(ok);
        check_output("b2b_accept", 32'(ok), 32'd1);
        bus.cmd_op   = 2'b10;
        bus.cmd_data = 8'h3C;
        rv_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            ss[c] = SS_n;
            mo[c] = MOSI;
            if (bus.rsp_valid === 1'b1) rv_cnt++;
            if (c == 5) begin
                check_output("b2b_ready_busy", 32'(bus.cmd_ready), 32'd0);
                check_output("b2b_busy",       32'(busy),          32'd1);
            end
            if (c == 20) bus.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        low_cnt = 0;
        for (int c = 0; c < 12; c++) if (ss[c] === 1'b0) low_cnt++;
        gap = 0;
        for (int c = 12; c < 40; c++) begin
            if (ss[c] !== 1'b1) break;
            gap++;
        end
        for (int c = 1; c <= 11; c++) begin
            f1[11 - c] = mo[c];
            f2[11 - c] = mo[c + 14];
        end
        check_output("b2b_sel_mosi",  32'(mo[0]),  32'd0);
        check_output("b2b_f1_low",    32'(low_cnt), 32'd12);
        check_output("b2b_gap",       32'(gap),     32'd2);
        check_output("b2b_f1_mosi",   32'(f1),      32'(11'b001_1010_0101));
        check_output("b2b_f2_mosi",   32'(f2),      32'(11'b110_0011_1100));
        check_output("b2b_f2_end",    32'(ss[26]),  32'd1);
        check_output("b2b_no_third",  32'(ss[30]),  32'd1);
        check_output("b2b_no_rsp",    32'(rv_cnt),  32'd0);

        // Reset in the middle of a read-data frame
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_data  = 8'h00;
        wait_accept(ok);
        bus.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("mid_in_frame", 32'(SS_n), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("mid_rst_ss_n",      32'(SS_n),          32'd1);
        check_output("mid_rst_mosi",      32'(MOSI),          32'd0);
        check_output("mid_rst_ready",     32'(bus.cmd_ready), 32'd1);
        check_output("mid_rst_busy",      32'(busy),          32'd0);
        check_output("mid_rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        rv_cnt = 0;
        low_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.rsp_valid === 1'b1) rv_cnt++;
            if (SS_n !== 1'b1) low_cnt++;
            @(posedge clk);
            #1;
        end
        check_output("mid_rst_no_rsp",   32'(rv_cnt),  32'd0);
        check_output("mid_rst_ss_quiet", 32'(low_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
